// File: rtl/vga_rect_fill.sv
// Rectangle-fill drawing engine: takes one fill command per handshake and
// streams frame-buffer pixel writes in raster order, with write backpressure.
module vga_rect_fill #(
  parameter int unsigned H_RES   = 1280,
  parameter int unsigned V_RES   = 1024,
  parameter int unsigned COORD_W = 11,
  parameter int unsigned COLOR_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COORD_W-1:0] cmd_x0_i,
  input  logic [COORD_W-1:0] cmd_y0_i,
  input  logic [COORD_W-1:0] cmd_x1_i,
  input  logic [COORD_W-1:0] cmd_y1_i,
  input  logic [COLOR_W-1:0] cmd_color_i,
  input  logic               cmd_clear_i,
  input  logic               abort_i,
  input  logic               wr_ready_i,
  output logic               we_o,
  output logic [COORD_W-1:0] addr_x_o,
  output logic [COORD_W-1:0] addr_y_o,
  output logic [COLOR_W-1:0] color_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic                 clear_q, clear_d;
  logic [COORD_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;

  logic [COORD_W-1:0]   xa, xb, ya, yb;
  logic [COORD_W-1:0]   xlo, xhi, ylo, yhi;

  always_comb begin
    // Clamping before min/max is equivalent to clamping after, since both are monotonic.
    xa  = (x0_q > X_LAST) ? X_LAST : x0_q;
    xb  = (x1_q > X_LAST) ? X_LAST : x1_q;
    ya  = (y0_q > Y_LAST) ? Y_LAST : y0_q;
    yb  = (y1_q > Y_LAST) ? Y_LAST : y1_q;
    xlo = (xa < xb) ? xa : xb;
    xhi = (xa < xb) ? xb : xa;
    ylo = (ya < yb) ? ya : yb;
    yhi = (ya < yb) ? yb : ya;
    if (clear_q) begin
      xlo = '0;
      xhi = X_LAST;
      ylo = '0;
      yhi = Y_LAST;
    end

    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    clear_d = clear_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    color_d = color_q;
    we_d    = we_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        we_d = 1'b0;
        if (cmd_valid_i) begin
          x0_d    = cmd_x0_i;
          y0_d    = cmd_y0_i;
          x1_d    = cmd_x1_i;
          y1_d    = cmd_y1_i;
          color_d = cmd_color_i;
          clear_d = cmd_clear_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        xmin_d  = xlo;
        xmax_d  = xhi;
        ymin_d  = ylo;
        ymax_d  = yhi;
        cur_x_d = xlo;
        cur_y_d = ylo;
        we_d    = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (abort_i) begin
          we_d    = 1'b0;
          state_d = S_IDLE;
        end else if (wr_ready_i) begin
          if (cur_x_q == xmax_q) begin
            if (cur_y_q == ymax_q) begin
              we_d    = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              cur_x_d = xmin_q;
              cur_y_d = cur_y_q + COORD_W'(1);
            end
          end else begin
            cur_x_d = cur_x_q + COORD_W'(1);
          end
        end
      end
      S_DONE: begin
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      clear_q <= 1'b0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      clear_q <= clear_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      color_q <= color_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign we_o        = we_q;
  assign addr_x_o    = cur_x_q;
  assign addr_y_o    = cur_y_q;
  assign color_o     = color_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Randomised bench for vga_rect_fill: a full-size instance plus a small-screen
// instance so that a complete clear pass fits in a short run.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, cmd_valid, cmd_clear, abort_i, wr_ready, sel;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [1:0]  cmd_color;

  logic        m_ready, m_we, m_busy, m_done;
  logic [10:0] m_x, m_y;
  logic [1:0]  m_color;
  logic        s_ready, s_we, s_busy, s_done;
  logic [10:0] s_x, s_y;
  logic [1:0]  s_color;

  logic        o_ready, o_we, o_busy, o_done;
  logic [10:0] o_x, o_y;
  logic [1:0]  o_color;

  int checks = 0;
  int failures = 0;
  int hres = 1280;
  int vres = 1024;
  int h_x0, h_y0, h_x1, h_y1, h_col;

  vga_rect_fill u_main (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(m_ready),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color), .cmd_clear_i(cmd_clear), .abort_i(abort_i & ~sel),
    .wr_ready_i(wr_ready), .we_o(m_we), .addr_x_o(m_x), .addr_y_o(m_y),
    .color_o(m_color), .busy_o(m_busy), .done_o(m_done)
  );

  vga_rect_fill #(.H_RES(48), .V_RES(24), .COORD_W(11), .COLOR_W(2)) u_small (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(s_ready),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_x1_i(cmd_x1), .cmd_y1_i(cmd_y1),
    .cmd_color_i(cmd_color), .cmd_clear_i(cmd_clear), .abort_i(abort_i & sel),
    .wr_ready_i(wr_ready), .we_o(s_we), .addr_x_o(s_x), .addr_y_o(s_y),
    .color_o(s_color), .busy_o(s_busy), .done_o(s_done)
  );

  always_comb begin
    o_ready = sel ? s_ready : m_ready;
    o_we    = sel ? s_we    : m_we;
    o_busy  = sel ? s_busy  : m_busy;
    o_done  = sel ? s_done  : m_done;
    o_x     = sel ? s_x     : m_x;
    o_y     = sel ? s_y     : m_y;
    o_color = sel ? s_color : m_color;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // stall_mode: 0 always ready, 1 random, 2 three-cycle stall on pixel (1,0)
  // stop_kind:  0 run to completion, 1 abort, 2 reset, when stop_after pixels are done
  task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input bit clr, input int stall_mode,
                         input int stop_kind, input int stop_after, input bit hold);
    int a, b, xmin, xmax, ymin, ymax, w, n, idx, cyc, stalls, bp, ex, ey;
    bit rdy;
    a = (ax0 >= hres) ? hres - 1 : ax0;
    b = (ax1 >= hres) ? hres - 1 : ax1;
    xmin = (a < b) ? a : b;
    xmax = (a < b) ? b : a;
    a = (ay0 >= vres) ? vres - 1 : ay0;
    b = (ay1 >= vres) ? vres - 1 : ay1;
    ymin = (a < b) ? a : b;
    ymax = (a < b) ? b : a;
    if (clr) begin
      xmin = 0; xmax = hres - 1; ymin = 0; ymax = vres - 1;
    end
    w = xmax - xmin + 1;
    n = w * (ymax - ymin + 1);

    cmd_x0 = 11'(ax0); cmd_y0 = 11'(ay0); cmd_x1 = 11'(ax1); cmd_y1 = 11'(ay1);
    cmd_color = 2'(col); cmd_clear = clr; cmd_valid = 1'b1;
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) chk("accept_timeout", 32'(cyc), 0);
    @(negedge clk);
    if (hold) begin
      cmd_x0 = 11'(h_x0); cmd_y0 = 11'(h_y0); cmd_x1 = 11'(h_x1); cmd_y1 = 11'(h_y1);
      cmd_color = 2'(h_col); cmd_clear = 1'b0;
    end else begin
      cmd_valid = 1'b0;
      cmd_x0 = 11'($urandom); cmd_y0 = 11'($urandom); cmd_x1 = 11'($urandom);
      cmd_y1 = 11'($urandom); cmd_color = 2'($urandom); cmd_clear = 1'($urandom);
    end
    chk("setup_we", 32'(o_we), 0);
    chk("setup_busy", 32'(o_busy), 1);
    chk("setup_ready", 32'(o_ready), 0);

    idx = 0; cyc = 0; stalls = 0; bp = 0;
    while (idx < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      cyc++;
      ex = xmin + idx % w;
      ey = ymin + idx / w;
      chk("fill_we", 32'(o_we), 1);
      chk("fill_x", 32'(o_x), 32'(ex));
      chk("fill_y", 32'(o_y), 32'(ey));
      chk("fill_color", 32'(o_color), 32'(col));
      chk("fill_busy", 32'(o_busy), 1);
      chk("fill_ready", 32'(o_ready), 0);
      chk("fill_done", 32'(o_done), 0);
      if (stop_kind != 0 && idx == stop_after) begin
        if (stop_kind == 1) begin
          abort_i = 1'b1;
          wr_ready = 1'($urandom);
          @(negedge clk);
          abort_i = 1'b0;
          wr_ready = 1'b1;
          chk("abort_we", 32'(o_we), 0);
          chk("abort_done", 32'(o_done), 0);
          chk("abort_ready", 32'(o_ready), 1);
          chk("abort_busy", 32'(o_busy), 0);
          @(negedge clk);
          chk("abort_done2", 32'(o_done), 0);
          chk("abort_we2", 32'(o_we), 0);
        end else begin
          rst_i = 1'b1;
          @(negedge clk);
          rst_i = 1'b0;
          wr_ready = 1'b1;
          chk("rst_we", 32'(o_we), 0);
          chk("rst_x", 32'(o_x), 0);
          chk("rst_y", 32'(o_y), 0);
          chk("rst_color", 32'(o_color), 0);
          chk("rst_busy", 32'(o_busy), 0);
          chk("rst_done", 32'(o_done), 0);
          chk("rst_ready", 32'(o_ready), 1);
        end
        return;
      end
      case (stall_mode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: begin
          rdy = !(ex == 1 && ey == 0 && bp < 3);
          if (!rdy) bp++;
        end
        default: rdy = 1'b1;
      endcase
      wr_ready = rdy;
      if (rdy) idx++;
      else stalls++;
    end
    if (idx < n) chk("fill_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    wr_ready = 1'b1;
    chk("fill_cycles", 32'(cyc), 32'(n + stalls));
    chk("done_pulse", 32'(o_done), 1);
    chk("done_we", 32'(o_we), 0);
    chk("done_busy", 32'(o_busy), 1);
    @(negedge clk);
    chk("idle_done", 32'(o_done), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_ready", 32'(o_ready), 1);
    chk("idle_we", 32'(o_we), 0);
  endtask

  initial begin
    int cx, cy;
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; abort_i = 1'b0; wr_ready = 1'b1;
    sel = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    h_x0 = 0; h_y0 = 0; h_x1 = 0; h_y1 = 0; h_col = 0;
    repeat (3) @(negedge clk);
    chk("reset_we", 32'(m_we), 0);
    chk("reset_x", 32'(m_x), 0);
    chk("reset_y", 32'(m_y), 0);
    chk("reset_color", 32'(m_color), 0);
    chk("reset_busy", 32'(m_busy), 0);
    chk("reset_done", 32'(m_done), 0);
    chk("reset_ready", 32'(m_ready), 1);
    rst_i = 1'b0;
    @(negedge clk);

    run_cmd(2, 3, 4, 4, 3, 1'b0, 0, 0, 0, 1'b0);
    run_cmd(4, 4, 2, 3, 3, 1'b0, 0, 0, 0, 1'b0);
    run_cmd(1278, 1023, 2000, 1500, 1, 1'b0, 0, 0, 0, 1'b0);
    run_cmd(0, 0, 3, 0, 2, 1'b0, 2, 0, 0, 1'b0);
    run_cmd(7, 9, 7, 9, 1, 1'b0, 0, 0, 0, 1'b0);
    run_cmd(1279, 1023, 1279, 1023, 2, 1'b0, 1, 0, 0, 1'b0);
    run_cmd(100, 200, 50, 60, 3, 1'b1, 1, 1, 1500, 1'b0);
    run_cmd(10, 10, 20, 15, 2, 1'b0, 1, 1, 17, 1'b0);
    run_cmd(10, 10, 20, 15, 2, 1'b0, 1, 2, 30, 1'b0);
    run_cmd(20, 15, 10, 10, 1, 1'b0, 1, 0, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      cx = $urandom_range(0, 1290);
      cy = $urandom_range(0, 1030);
      run_cmd(cx, cy, cx + $urandom_range(0, 10) - 5 < 0 ? 0 : cx + $urandom_range(0, 10) - 5,
              cy + $urandom_range(0, 8) - 4 < 0 ? 0 : cy + $urandom_range(0, 8) - 4,
              $urandom_range(0, 3), 1'b0, 1, 0, 0, 1'b0);
    end

    sel = 1'b1; hres = 48; vres = 24;
    @(negedge clk);
    h_x0 = 5; h_y0 = 5; h_x1 = 5; h_y1 = 5; h_col = 2;
    run_cmd(30, 3, 9, 17, 0, 1'b1, 0, 0, 0, 1'b1);
    run_cmd(5, 5, 5, 5, 2, 1'b0, 0, 0, 0, 1'b0);
    run_cmd(60, 30, 40, 20, 3, 1'b0, 1, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
